// File: rtl/ysyx_25060170_mem_arbiter.sv
// ysyx_25060170_mem_arbiter: serializes IFU and LSU traffic onto one memory port, one transaction at a time
// Ports: ifu_* read-only fetch master, lsu_* load/store master, mem_* shared memory port,
//        grant_id owner of current/last transaction (1 = LSU), busy when not idle,
//        proto_err sticky flag for a memory response arriving outside WAIT.
module ysyx_25060170_mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ifu_req_valid,
  output logic                ifu_req_ready,
  input  logic [ADDR_W-1:0]   ifu_addr,
  output logic                ifu_resp_valid,
  output logic [DATA_W-1:0]   ifu_rdata,
  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic                lsu_wen,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wmask,
  output logic                lsu_resp_valid,
  output logic [DATA_W-1:0]   lsu_rdata,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic                mem_wen,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_resp_valid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                grant_id,
  output logic                busy,
  output logic                proto_err
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  state_t                r_state;
  logic [SW-1:0]         r_starve_cnt;
  logic                  r_grant_id, r_proto_err, r_wen;
  logic [ADDR_W-1:0]     r_addr;
  logic [DATA_W-1:0]     r_wdata;
  logic [DATA_W/8-1:0]   r_wmask;
  logic                  w_idle, w_starved, w_gnt_ifu, w_gnt_lsu, w_resp;
  assign w_idle    = r_state == IDLE;
  assign w_starved = r_starve_cnt == SW'(STARVE_LIMIT);
  // LSU has priority unless IFU has lost STARVE_LIMIT contended rounds in a row
  assign w_gnt_ifu = w_idle && ifu_req_valid && (!lsu_req_valid || w_starved);
  assign w_gnt_lsu = w_idle && lsu_req_valid && !w_gnt_ifu;
  // responses outside WAIT are dropped and only flagged
  assign w_resp    = r_state == WAIT && mem_resp_valid;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_starve_cnt <= '0;
      r_grant_id   <= 1'b0;
      r_proto_err  <= 1'b0;
      r_wen        <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_wmask      <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_gnt_ifu || w_gnt_lsu) begin
          r_state    <= REQ;
          r_grant_id <= w_gnt_lsu;
          r_wen      <= w_gnt_lsu && lsu_wen;
          r_addr     <= w_gnt_lsu ? lsu_addr : ifu_addr;
          r_wdata    <= w_gnt_lsu ? lsu_wdata : '0;
          r_wmask    <= w_gnt_lsu ? lsu_wmask : '0;
        end
        REQ:     if (mem_req_ready) r_state <= WAIT;
        WAIT:    if (mem_resp_valid) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
      if (w_gnt_ifu) r_starve_cnt <= '0;
      else if (w_gnt_lsu && ifu_req_valid && !w_starved) r_starve_cnt <= r_starve_cnt + SW'(1);
      if (mem_resp_valid && r_state != WAIT) r_proto_err <= 1'b1;
    end
  end
  assign ifu_req_ready  = w_gnt_ifu;
  assign lsu_req_ready  = w_gnt_lsu;
  assign ifu_resp_valid = w_resp && !r_grant_id;
  assign lsu_resp_valid = w_resp && r_grant_id;
  assign ifu_rdata      = mem_rdata;
  assign lsu_rdata      = mem_rdata;
  assign mem_req_valid  = r_state == REQ;
  assign mem_wen        = r_wen;
  assign mem_addr       = r_addr;
  assign mem_wdata      = r_wdata;
  assign mem_wmask      = r_wmask;
  assign grant_id       = r_grant_id;
  assign busy           = !w_idle;
  assign proto_err      = r_proto_err;
endmodule

// File: doc/ysyx_25060170_mem_arbiter.md
# ysyx_25060170_mem_arbiter

Two-master, single-port memory arbiter for the ysyx_25060170 core. It shares one memory request/response port between the instruction fetch unit (IFU) and the load/store unit (LSU). Only one transaction is outstanding at a time. The LSU has fixed priority, with a starvation guard that guarantees IFU progress. It sits between the IFU/LSU stages and the memory/bus bridge, and it is the single point where the core's memory traffic is serialized.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width; mask width is DATA_W/8
- STARVE_LIMIT, 4, number of consecutive LSU-over-IFU wins before IFU is forced; must be ≥1

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- ifu_req_valid  in  1  IFU read request
- ifu_req_ready  out  1  IFU request accepted this cycle
- ifu_addr  in  ADDR_W  IFU fetch address
- ifu_resp_valid  out  1  IFU read data valid (one-cycle pulse)
- ifu_rdata  out  DATA_W  IFU read data
- lsu_req_valid  in  1  LSU request
- lsu_req_ready  out  1  LSU request accepted this cycle
- lsu_wen  in  1  1 = store, 0 = load
- lsu_addr  in  ADDR_W  LSU address
- lsu_wdata  in  DATA_W  store data
- lsu_wmask  in  DATA_W/8  store byte mask
- lsu_resp_valid  out  1  LSU response valid (load data or store ack), one-cycle pulse
- lsu_rdata  out  DATA_W  load data
- mem_req_valid  out  1  request to memory
- mem_req_ready  in  1  memory accepts request
- mem_wen, mem_addr, mem_wdata, mem_wmask  out  1/ADDR_W/DATA_W/DATA_W/8  latched request payload
- mem_resp_valid  in  1  memory response
- mem_rdata  in  DATA_W  memory read data
- grant_id  out  1  owner of current/last transaction: 0 = IFU, 1 = LSU
- busy  out  1  high whenever state ≠ IDLE
- proto_err  out  1  sticky; set on a mem_resp_valid outside WAIT

## Operation
- FSM has three states: IDLE, REQ, WAIT.
- **IDLE, grant decision** (combinational on the valids):
  - Only one master valid: that master wins.
  - Both valid: LSU wins, unless starve_cnt == STARVE_LIMIT, in which case IFU wins.
- **IDLE, on a grant:**
  - Assert the winner's *_req_ready for that one cycle.
  - Latch the winner's payload into the mem_* registers. IFU forces wen=0, wdata=0, mask=0.
  - Set grant_id to the winner and go to REQ.
- **REQ:** mem_req_valid=1 with a stable payload. On mem_req_ready, go to WAIT.
- **WAIT:**
  - mem_req_valid=0.
  - On mem_resp_valid, pulse the owner's *_resp_valid combinationally and pass mem_rdata to the owner's rdata. The non-owner's resp_valid stays 0.
  - Return to IDLE.
- **starve_cnt** (width $clog2(STARVE_LIMIT+1)):
  - Increments, saturating, on an IDLE grant to LSU while ifu_req_valid=1.
  - Clears on any IFU grant.
  - Otherwise holds.
- **Master obligations:** a master holds valid and payload stable until it sees ready. Ready never asserts outside IDLE.
- **proto_err:** set when mem_resp_valid=1 in IDLE or REQ. That response is dropped and is not routed. Cleared only by rst.
- ifu_rdata/lsu_rdata mirror mem_rdata at all times; they are qualified only by resp_valid.

## Timing
- **Reset values:**
  - state=IDLE
  - mem_req_valid=0; mem_wen/addr/wdata/wmask=0
  - grant_id=0, starve_cnt=0, proto_err=0
  - busy=0, all ready/resp_valid=0
- **Latency:** grant in cycle T (IDLE) → mem_req_valid from T+1 → earliest WAIT at T+2 (mem_req_ready at T+1) → earliest response at T+2 → next grant at T+3. Minimum 3 cycles per transaction plus memory latency.
- **Same-cycle events:**
  - mem_resp_valid in the same cycle as mem_req_ready is illegal. It is treated as out-of-WAIT and sets proto_err.
  - Both masters valid in the same cycle: exactly one ready is asserted; the loser's valid stays pending.
- **Reset mid-transaction** (REQ or WAIT): returns to IDLE next cycle and drops the outstanding transaction with no resp_valid. The memory side shares rst.
- **Sustained contention** with both valid: IFU is granted at least once per STARVE_LIMIT+1 grants.

## Test plan
- **Reset mid-WAIT:**
  - Stimulus: LSU load to 0x8000_0010; assert rst one cycle during WAIT.
  - Required: next cycle busy=0, mem_req_valid=0, no lsu_resp_valid, proto_err=0.
- **Single IFU fetch:**
  - Stimulus: ifu addr=0x8000_0000; memory ready immediately; rdata=0x0010_0073 after 2 cycles.
  - Required: ifu_req_ready at T; mem_addr=0x8000_0000, mem_wen=0 at T+1; ifu_resp_valid one cycle with 0x0010_0073; lsu_resp_valid never asserts.
- **LSU store:**
  - Stimulus: addr=0x8000_1004, wdata=0xDEADBEEF, wmask=0xF.
  - Required: mem_* carries exactly those values with mem_wen=1; lsu_resp_valid pulses once on the ack; grant_id=1.
- **Simultaneous requests, STARVE_LIMIT=4, both valid continuously:**
  - Required grant sequence: L,L,L,L,I,L,L,L,L,I.
  - starve_cnt reads 4 before each I grant and 0 after it.
- **Memory backpressure:**
  - Stimulus: mem_req_ready low for 5 cycles in REQ.
  - Required: mem_req_valid and payload stable throughout; no ready to either master; busy=1.
- **Spurious response:**
  - Stimulus: mem_resp_valid pulsed while IDLE.
  - Required: proto_err=1 from the next cycle and sticky; no resp_valid to either master; subsequent IFU fetch completes normally.
